// File: rtl/lab2_proc_alu_arbiter_pkg.sv
// Shared types and constants for the lab2 ALU arbiter: FSM states, ALU
// function codes, message widths and field offsets.
package lab2_proc_alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_MUL  = 4'd2;
    localparam logic [3:0] FN_AND  = 4'd3;
    localparam logic [3:0] FN_OR   = 4'd4;
    localparam logic [3:0] FN_XOR  = 4'd5;
    localparam logic [3:0] FN_SLT  = 4'd6;
    localparam logic [3:0] FN_SLTU = 4'd7;
    localparam logic [3:0] FN_SRA  = 4'd8;
    localparam logic [3:0] FN_SRL  = 4'd9;
    localparam logic [3:0] FN_SLL  = 4'd10;
    localparam logic [3:0] FN_CPY0 = 4'd11;
    localparam logic [3:0] FN_CPY1 = 4'd12;

    localparam int REQ_MSG_W  = 68;
    localparam int RESP_MSG_W = 35;

    // Request message: {fn, in0, in1}
    localparam int REQ_FN_OFF  = 64;
    localparam int REQ_IN0_OFF = 32;
    localparam int REQ_IN1_OFF = 0;

    // Response message: {out, ops_eq, ops_lt, ops_ltu}
    localparam int RESP_OUT_OFF = 3;
    localparam int RESP_EQ_OFF  = 2;
    localparam int RESP_LT_OFF  = 1;
    localparam int RESP_LTU_OFF = 0;

endpackage

// File: rtl/lab2_proc_alu_arbiter_if.sv
// Request/response bundle between p_nreqs requesters (master) and the
// shared-ALU arbiter (slave).
interface lab2_proc_alu_arbiter_if #(
    parameter int p_nreqs = 2
) ();
    import lab2_proc_alu_arb_pkg::*;

    logic [p_nreqs-1:0]           req_val;
    logic [p_nreqs-1:0]           req_rdy;
    logic [p_nreqs*REQ_MSG_W-1:0] req_msg;
    logic [p_nreqs-1:0]           resp_val;
    logic [p_nreqs-1:0]           resp_rdy;
    logic [RESP_MSG_W-1:0]        resp_msg;

    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

endinterface

// File: rtl/lab2_proc_alu_arbiter_alu.sv
// Combinational 32-bit ALU (lab2_proc_AluVRTL) plus eq/lt/ltu comparators
// that are evaluated on the operands regardless of the function code.
module lab2_proc_AluVRTL (
    input  logic [3:0]  fn,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic [31:0] out,
    output logic        ops_eq,
    output logic        ops_lt,
    output logic        ops_ltu
);
    import lab2_proc_alu_arb_pkg::*;

    logic signed [31:0] sra_s;

    assign sra_s = $signed(in0) >>> in1[4:0];

    // Function-code decode; unused codes return zero.
    always_comb begin
        out = 32'd0;
        case (fn)
            FN_ADD:  out = in0 + in1;
            FN_SUB:  out = in0 - in1;
            FN_MUL:  out = in0 * in1;
            FN_AND:  out = in0 & in1;
            FN_OR:   out = in0 | in1;
            FN_XOR:  out = in0 ^ in1;
            FN_SLT:  out = {31'd0, ($signed(in0) < $signed(in1))};
            FN_SLTU: out = {31'd0, (in0 < in1)};
            FN_SRA:  out = sra_s;
            FN_SRL:  out = in0 >> in1[4:0];
            FN_SLL:  out = in0 << in1[4:0];
            FN_CPY0: out = in0;
            FN_CPY1: out = in1;
            default: out = 32'd0;
        endcase
    end

    assign ops_eq  = (in0 == in1);
    assign ops_lt  = ($signed(in0) < $signed(in1));
    assign ops_ltu = (in0 < in1);

endmodule

// File: rtl/lab2_proc_alu_arbiter.sv
// Shares one ALU among p_nreqs requesters with an IDLE/EXEC/RESP FSM.
// Define LAB2_PROC_ALU_ARB_FIXED_PRIO_EN for lowest-index-first priority instead of round-robin.
module lab2_proc_alu_arbiter #(
    parameter int p_nreqs = 2
) (
    input logic                   clk,
    input logic                   reset,
    lab2_proc_alu_arbiter_if.slave bus
);
    import lab2_proc_alu_arb_pkg::*;

    localparam int c_iw = (p_nreqs > 2) ? 2 : 1;

    state_e                state_r;
    state_e                next_state_s;
    logic [c_iw-1:0]       owner_r;
    logic [c_iw-1:0]       grant_idx_s;
    logic                  any_val_s;
    logic                  fire_s;
    int                    cand_s;
    logic [REQ_MSG_W-1:0]  sel_msg_s;
    logic [3:0]            fn_r;
    logic [31:0]           in0_r;
    logic [31:0]           in1_r;
    logic [RESP_MSG_W-1:0] resp_r;
    logic [RESP_MSG_W-1:0] resp_nxt_s;
    logic [p_nreqs-1:0]    req_rdy_s;
    logic [p_nreqs-1:0]    resp_val_s;
    logic [31:0]           alu_out_s;
    logic                  alu_eq_s;
    logic                  alu_lt_s;
    logic                  alu_ltu_s;
`ifndef LAB2_PROC_ALU_ARB_FIXED_PRIO_EN
    logic [c_iw-1:0]       ptr_r;
    logic [c_iw-1:0]       ptr_nxt_s;
`endif

    // Grant search: first valid requester from the scan start, wrapping around.
    always_comb begin
        grant_idx_s = {c_iw{1'b0}};
        any_val_s   = 1'b0;
        cand_s      = 0;
        for (int k = 0; k < p_nreqs; k++) begin
`ifdef LAB2_PROC_ALU_ARB_FIXED_PRIO_EN
            cand_s = k;
`else
            cand_s = int'(ptr_r) + k;
            cand_s = (cand_s >= p_nreqs) ? (cand_s - p_nreqs) : cand_s;
`endif
            if (!any_val_s && bus.req_val[cand_s[c_iw-1:0]]) begin
                any_val_s   = 1'b1;
                grant_idx_s = cand_s[c_iw-1:0];
            end else begin
                any_val_s   = any_val_s;
            end
        end
    end

    // Mux out the winner's request message.
    always_comb begin
        sel_msg_s = {REQ_MSG_W{1'b0}};
        for (int i = 0; i < p_nreqs; i++) begin
            if (grant_idx_s == i[c_iw-1:0]) begin
                sel_msg_s = bus.req_msg[i*REQ_MSG_W +: REQ_MSG_W];
            end else begin
                sel_msg_s = sel_msg_s;
            end
        end
    end

    // Next-state and handshake decode; ready is also gated by reset so nothing fires while held.
    always_comb begin
        next_state_s = state_r;
        req_rdy_s    = {p_nreqs{1'b0}};
        resp_val_s   = {p_nreqs{1'b0}};
        fire_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_val_s && reset) begin
                    req_rdy_s[grant_idx_s] = 1'b1;
                    fire_s                 = 1'b1;
                    next_state_s           = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: next_state_s = ST_RESP;
            ST_RESP: begin
                resp_val_s[owner_r] = 1'b1;
                if (bus.resp_rdy[owner_r]) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Pack ALU results into the response layout.
    always_comb begin
        resp_nxt_s                      = {RESP_MSG_W{1'b0}};
        resp_nxt_s[RESP_OUT_OFF +: 32]  = alu_out_s;
        resp_nxt_s[RESP_EQ_OFF]         = alu_eq_s;
        resp_nxt_s[RESP_LT_OFF]         = alu_lt_s;
        resp_nxt_s[RESP_LTU_OFF]        = alu_ltu_s;
    end

    // FSM state, captured operands/owner and the response register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            owner_r <= {c_iw{1'b0}};
            fn_r    <= 4'd0;
            in0_r   <= 32'd0;
            in1_r   <= 32'd0;
            resp_r  <= {RESP_MSG_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (fire_s) begin
                owner_r <= grant_idx_s;
                fn_r    <= sel_msg_s[REQ_FN_OFF +: 4];
                in0_r   <= sel_msg_s[REQ_IN0_OFF +: 32];
                in1_r   <= sel_msg_s[REQ_IN1_OFF +: 32];
            end
            if (state_r == ST_EXEC) begin
                resp_r <= resp_nxt_s;
            end
        end
    end

`ifndef LAB2_PROC_ALU_ARB_FIXED_PRIO_EN
    assign ptr_nxt_s = ((int'(grant_idx_s) + 1) >= p_nreqs) ? {c_iw{1'b0}} : (grant_idx_s + 1'b1);

    // Round-robin pointer moves past the winner only when a request fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= {c_iw{1'b0}};
        end else if (fire_s) begin
            ptr_r <= ptr_nxt_s;
        end
    end
`endif

    lab2_proc_AluVRTL u_alu (
        .fn      (fn_r),
        .in0     (in0_r),
        .in1     (in1_r),
        .out     (alu_out_s),
        .ops_eq  (alu_eq_s),
        .ops_lt  (alu_lt_s),
        .ops_ltu (alu_ltu_s)
    );

    assign bus.req_rdy  = req_rdy_s;
    assign bus.resp_val = resp_val_s;
    assign bus.resp_msg = resp_r;

endmodule
